// File: rtl/hdlc_pkg.sv
// Shared definitions for the HDLC transmit sequencer slice.
package hdlc_pkg;

  // FIFO entry is {last, data}
  localparam int unsigned ENTRY_W = 9;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_SEND  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_GAP   = 3'd4,
    ST_FLUSH = 3'd5
  } txState_e;

  function automatic logic isLast(input logic [ENTRY_W-1:0] entry);
    return entry[ENTRY_W-1];
  endfunction

endpackage

// File: rtl/hdlc_sync_fifo.sv
// Single-clock FIFO with combinational head output and registered full/empty flags.
module hdlc_sync_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     Clk,
  input  logic                     Rstn,
  input  logic                     Push,
  input  logic [WIDTH-1:0]         PushData,
  input  logic                     Pop,
  output logic [WIDTH-1:0]         PopData,
  output logic [$clog2(DEPTH):0]   Level,
  output logic                     Full,
  output logic                     Empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic [AW:0]      levelNext;
  logic             doPush;
  logic             doPop;

  assign doPush  = Push & ~Full;
  assign doPop   = Pop & ~Empty;
  assign PopData = mem[rdPtr];

  // Occupancy after this cycle's push/pop
  always_comb begin
    levelNext = Level;
    case ({doPush, doPop})
      2'b10:   levelNext = Level + 1'b1;
      2'b01:   levelNext = Level - 1'b1;
      default: levelNext = Level;
    endcase
  end

  // Pointers, level and flags; flags precomputed from next level so they are registered
  always_ff @(posedge Clk) begin
    if (!Rstn) begin
      wrPtr <= '0;
      rdPtr <= '0;
      Level <= '0;
      Full  <= 1'b0;
      Empty <= 1'b1;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      Level <= levelNext;
      Full  <= (levelNext == (AW+1)'(DEPTH));
      Empty <= (levelNext == '0);
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge Clk) begin
    if (doPush) mem[wrPtr] <= PushData;
  end

endmodule

// File: rtl/hdlc_tx_seq.sv
// HDLC transmit sequencer: buffers framed bytes and paces them into the transmitter.
module hdlc_tx_seq
  import hdlc_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned PREFILL    = 4,
  parameter int unsigned GAP_CYCLES = 16
) (
  input  logic        Clk,
  input  logic        Rstn,
  input  logic        En,
  input  logic [7:0]  S_Data,
  input  logic        S_Last,
  input  logic        S_Valid,
  output logic        S_Ready,
  output logic [7:0]  TxInputData,
  input  logic        TxInputReq,
  output logic        TxEmpty,
  output logic        TxStart,
  output logic        TxAbort,
  input  logic        TxBusy,
  input  logic        SwAbort,
  output logic        FrameDone,
  output logic        FrameAborted,
  output logic [15:0] FrameCnt,
  output logic [15:0] AbortCnt,
  output logic [2:0]  State
);

  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  txState_e             state;
  txState_e             stateNext;
  logic [ENTRY_W-1:0]   headEntry;
  logic [LW-1:0]        fifoLevel;
  logic                 fifoFull;
  logic                 fifoEmpty;
  logic [LW-1:0]        lastCnt;
  logic                 lastPopped;
  logic [15:0]          gapCnt;
  logic                 push;
  logic                 pop;
  logic                 headLast;
  logic                 startPulse;
  logic                 abortPulse;
  logic                 donePulse;
  logic                 setLastPopped;
  logic                 clrLastPopped;

  assign S_Ready     = ~fifoFull;
  assign push        = S_Valid & S_Ready;
  assign headLast    = isLast(headEntry);
  assign TxInputData = headEntry[7:0];
  assign TxEmpty     = (state == ST_SEND) ? lastPopped : 1'b1;
  assign State       = state;

  // Pulses are masked during reset so a reset mid-frame never signals an abort
  assign TxStart      = startPulse & Rstn;
  assign TxAbort      = abortPulse & Rstn;
  assign FrameAborted = abortPulse & Rstn;
  assign FrameDone    = donePulse & Rstn;

  hdlc_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) uFifo (
    .Clk      (Clk),
    .Rstn     (Rstn),
    .Push     (push),
    .PushData ({S_Last, S_Data}),
    .Pop      (pop),
    .PopData  (headEntry),
    .Level    (fifoLevel),
    .Full     (fifoFull),
    .Empty    (fifoEmpty)
  );

  // State register, frame bookkeeping and counters
  always_ff @(posedge Clk) begin
    if (!Rstn) begin
      state      <= ST_IDLE;
      lastCnt    <= '0;
      lastPopped <= 1'b0;
      gapCnt     <= '0;
      FrameCnt   <= '0;
      AbortCnt   <= '0;
    end else begin
      state <= stateNext;
      case ({push & S_Last, pop & headLast})
        2'b10:   lastCnt <= lastCnt + 1'b1;
        2'b01:   lastCnt <= lastCnt - 1'b1;
        default: lastCnt <= lastCnt;
      endcase
      if (clrLastPopped)      lastPopped <= 1'b0;
      else if (setLastPopped) lastPopped <= 1'b1;
      if (state == ST_GAP && stateNext == ST_GAP) gapCnt <= gapCnt + 16'd1;
      else                                        gapCnt <= '0;
      if (donePulse)  FrameCnt <= FrameCnt + 16'd1;
      if (abortPulse) AbortCnt <= AbortCnt + 16'd1;
    end
  end

  // Next-state, pop and pulse decode
  always_comb begin
    stateNext     = state;
    pop           = 1'b0;
    startPulse    = 1'b0;
    abortPulse    = 1'b0;
    donePulse     = 1'b0;
    setLastPopped = 1'b0;
    clrLastPopped = 1'b0;
    case (state)
      ST_IDLE: begin
        if (En && !TxBusy && (lastCnt != '0 || 32'(fifoLevel) >= PREFILL))
          stateNext = ST_START;
      end
      ST_START: begin
        clrLastPopped = 1'b1;
        if (SwAbort) begin
          abortPulse = 1'b1;
          stateNext  = ST_FLUSH;
        end else begin
          startPulse = 1'b1;
          stateNext  = ST_SEND;
        end
      end
      ST_SEND: begin
        // Software abort wins over a coincident byte request
        if (SwAbort) begin
          abortPulse = 1'b1;
          stateNext  = ST_FLUSH;
        end else if (TxInputReq) begin
          if (lastPopped) begin
            stateNext = ST_DRAIN;
          end else if (fifoEmpty) begin
            abortPulse = 1'b1;
            stateNext  = ST_FLUSH;
          end else begin
            pop = 1'b1;
            if (headLast) setLastPopped = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (!TxBusy) begin
          donePulse = 1'b1;
          stateNext = ST_GAP;
        end
      end
      ST_GAP: begin
        if (32'(gapCnt) + 32'd1 >= GAP_CYCLES) stateNext = ST_IDLE;
      end
      ST_FLUSH: begin
        if (!fifoEmpty) begin
          pop = 1'b1;
          if (headLast) stateNext = ST_GAP;
        end
      end
      default: stateNext = ST_IDLE;
    endcase
  end

endmodule

// File: doc/hdlc_tx_seq.md
HDLC_TX_SEQ -- requirements
Module: hdlc_tx_seq

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16 (power of 2, 4..256), meaning the byte FIFO depth.
REQ-002 SHALL have parameter PREFILL, default 4, meaning the FIFO level that starts an unterminated frame.
REQ-003 SHALL have parameter GAP_CYCLES, default 16, meaning the idle Clk cycles between frames.
REQ-004 SHALL have the following ports:
- Clk  in  1  clock; single clock.
- Rstn  in  1  synchronous active-low reset.
- En  in  1  permits new frame starts.
- S_Data  in  8  payload byte.
- S_Last  in  1  last byte of frame.
- S_Valid  in  1  byte offered.
- S_Ready  out  1  byte accepted when S_Valid&S_Ready.
- TxInputData  out  8  head byte to transmitter.
- TxInputReq  in  1  transmitter byte request, 1-cycle pulse.
- TxEmpty  out  1  no further bytes in current frame.
- TxStart  out  1  frame start, 1-cycle pulse.
- TxAbort  out  1  frame abort, 1-cycle pulse.
- TxBusy  in  1  transmitter active.
- SwAbort  in  1  software abort request, level-sampled.
- FrameDone  out  1  pulse, frame completed.
- FrameAborted  out  1  pulse, frame aborted.
- FrameCnt  out  16  completed frames, wraps.
- AbortCnt  out  16  aborted frames, wraps.
- State  out  3  current FSM state encoding.

Function
REQ-005 SHALL buffer 9-bit entries {S_Last,S_Data} in a FIFO; S_Ready = !full, registered; push when S_Valid&S_Ready.
REQ-006 SHALL track LastCnt = number of entries with the last flag set currently in the FIFO; push and pop in the same cycle SHALL net correctly.
REQ-007 SHALL drive TxInputData = FIFO head combinationally; value is undefined-but-stable when the FIFO is empty.
REQ-008 SHALL implement FSM states IDLE=0, START=1, SEND=2, DRAIN=3, GAP=4, FLUSH=5.
REQ-009 IDLE: when En & !TxBusy & (LastCnt>0 | level>=PREFILL), SHALL go to START.
REQ-010 START: SHALL assert TxStart for exactly one cycle, clear LastPopped, then go to SEND.
REQ-011 SEND: on TxInputReq with !TxEmpty and FIFO non-empty, SHALL pop the head; if the popped entry is last, SHALL set LastPopped.
REQ-012 TxEmpty SHALL be 1 in every state except SEND, and SHALL equal LastPopped in SEND.
REQ-013 SEND: on TxInputReq with TxEmpty=1, SHALL go to DRAIN.
REQ-014 Underrun, defined as TxInputReq & !TxEmpty & FIFO empty in SEND, SHALL cause a one-cycle TxAbort, a FrameAborted pulse and an AbortCnt increment, then FLUSH.
REQ-015 SwAbort=1 in START or SEND SHALL take priority over the same-cycle TxInputReq and have the REQ-014 effect.
REQ-016 SwAbort in IDLE, DRAIN or GAP SHALL be ignored.
REQ-017 FLUSH: SHALL pop entries until an entry with the last flag is popped (that pop included), then go to GAP.
REQ-018 FLUSH: SHALL wait while the FIFO is empty; a simultaneous push to an empty FIFO is popped the next cycle.
REQ-019 DRAIN: when TxBusy=0, SHALL pulse FrameDone, increment FrameCnt and go to GAP.
REQ-020 GAP: SHALL count GAP_CYCLES cycles, then return to IDLE; GAP_CYCLES=0 SHALL return after 1 cycle.
REQ-021 En deasserted mid-frame SHALL NOT interrupt the frame; it only blocks the IDLE->START transition.
REQ-022 Counters SHALL wrap 0xFFFF->0 without any flag.
REQ-023 A full FIFO with LastCnt=0 and level>=PREFILL SHALL start the frame normally.

Reset
REQ-024 On Rstn=0 at a Clk edge, SHALL empty the FIFO, set LastCnt=0, LastPopped=0, State=IDLE, S_Ready=1, TxEmpty=1, all pulses 0 and counters 0.
REQ-025 Reset mid-frame SHALL NOT emit TxAbort; the transmitter is reset by its own reset.

Structure
REQ-026 State encodings SHALL reside in shared package hdlc_pkg.
REQ-027 The FIFO SHALL be sub-module hdlc_sync_fifo (parameters WIDTH=9, DEPTH), exposing level, full and empty.

Verification
REQ-028 Push a 3-byte frame 0x11,0x22,0x33(last); ack 4 TxInputReq -> bytes popped in order, TxEmpty rises after 0x33, FrameDone once, FrameCnt=1.
REQ-029 Push 4 bytes with no last, stop; ack 5 TxInputReq -> 4 pops, then TxAbort pulse, FrameAborted, AbortCnt=1; next pushed byte with last is flushed, then IDLE.
REQ-030 Send two back-to-back frames -> exactly 16 GAP cycles between the FrameDone and the second TxStart.
REQ-031 Push 20 bytes continuously with depth 16 -> S_Ready=0 at level 16; no byte is lost or duplicated.
REQ-032 Assert SwAbort coincident with TxInputReq in SEND -> TxAbort, no pop on that cycle, FLUSH to last, AbortCnt increments.
REQ-033 Assert Rstn=0 mid-SEND -> the next cycle has State=0, S_Ready=1, counters 0, no TxAbort.
